// File: rtl/hcsr04_echo_responder_if.sv
// Trigger/echo link between a measurement initiator and the
// HC-SR04 responder model.
interface hcsr04_echo_responder_if #(
   parameter int DIST_W = 7
);
   logic              trig;
   logic [DIST_W-1:0] distance;
   logic              echo;
   logic              busy;
   logic              no_target;
   logic              runt;
   logic              done;

   modport master (
      output trig, distance,
      input  echo, busy, no_target, runt, done
   );

   modport slave (
      input  trig, distance,
      output echo, busy, no_target, runt, done
   );
endinterface

// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 sensor-side model: accepts a trigger pulse and answers
// with an echo whose width encodes the programmed distance.
module hcsr04_echo_responder #(
   parameter int DIST_W       = 7,
   parameter int TRIG_MIN_CYC = 6,
   parameter int BURST_CYC    = 8,
   parameter int CYC_PER_CM   = 1,
   parameter int CNT_W        = 16,
   parameter int ECHO_TIMEOUT = 100,
   parameter int HOLDOFF_CYC  = 4
) (
   input logic clk,
   input logic rst_n,
   hcsr04_echo_responder_if.slave bus
);
   localparam int PW = 2 * CNT_W;

   typedef enum logic [2:0] {
      IDLE, TRIG_HI, BURST, ECHO, HOLDOFF
   } state_t;

   state_t            state;
   logic              sync1;
   logic              trig_s;
   logic              trig_q;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  w_q;
   logic [DIST_W-1:0] dist_q;
   logic              echo_q;
   logic              nt_q;
   logic              runt_q;
   logic              done_q;

   logic [PW-1:0]     prod;
   logic              nt_calc;
   logic [CNT_W-1:0]  w_calc;
   logic              rise;

   // Double-width product so large distances saturate instead of wrapping
   always_comb begin
      prod    = PW'(dist_q) * PW'(CYC_PER_CM);
      nt_calc = (dist_q == '0) || (prod > PW'(ECHO_TIMEOUT));
      w_calc  = nt_calc ? CNT_W'(ECHO_TIMEOUT) : prod[CNT_W-1:0];
      rise    = trig_s & ~trig_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sync1  <= 1'b0;
         trig_s <= 1'b0;
         trig_q <= 1'b0;
         cnt    <= '0;
         w_q    <= '0;
         dist_q <= '0;
         echo_q <= 1'b0;
         nt_q   <= 1'b0;
         runt_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         sync1  <= bus.trig;
         trig_s <= sync1;
         trig_q <= trig_s;
         runt_q <= 1'b0;
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state <= TRIG_HI;
                  cnt   <= CNT_W'(1);
               end
            end
            TRIG_HI: begin
               if (trig_s) begin
                  if (cnt < CNT_W'(TRIG_MIN_CYC))
                     cnt <= cnt + 1'b1;
               end else if (cnt >= CNT_W'(TRIG_MIN_CYC)) begin
                  dist_q <= bus.distance;
                  cnt    <= '0;
                  state  <= BURST;
               end else begin
                  runt_q <= 1'b1;
                  cnt    <= '0;
                  state  <= IDLE;
               end
            end
            BURST: begin
               if (cnt == CNT_W'(BURST_CYC - 1)) begin
                  state  <= ECHO;
                  echo_q <= 1'b1;
                  nt_q   <= nt_calc;
                  w_q    <= w_calc;
                  cnt    <= CNT_W'(1);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ECHO: begin
               if (cnt == w_q) begin
                  echo_q <= 1'b0;
                  done_q <= 1'b1;
                  cnt    <= '0;
                  state  <= HOLDOFF;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLDOFF: begin
               if (cnt == CNT_W'(HOLDOFF_CYC - 1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.echo      = echo_q;
   assign bus.busy      = (state != IDLE);
   assign bus.no_target = nt_q;
   assign bus.runt      = runt_q;
   assign bus.done      = done_q;
endmodule
